// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types and constants for the pipeline hazard controller.
//               Forwarding-select encoding, controller FSM states, the x0
//               register index and a small forwarding-priority helper.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    // EX-stage operand source select
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,  // register file read data
        FWD_MEM = 2'b01,  // ALU result held in EX/MEM
        FWD_WB  = 2'b10   // write-back data in MEM/WB
    } fwd_sel_t;

    // Controller state
    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } hz_state_t;

    // Architectural zero register; never a forwarding source
    localparam int REG_X0 = 0;

    // The younger producer (MEM) holds the newest value, so it wins over WB.
    function automatic fwd_sel_t fwd_select(input logic mem_hit, input logic wb_hit);
        if (mem_hit) begin
            return FWD_MEM;
        end else if (wb_hit) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_perf_cnt.sv
`default_nettype none
// ============================================================================
// Module      : hazard_perf_cnt
// Description : Pair of saturating 32-bit event counters for the hazard
//               controller (stall cycles and taken-branch flush entries).
//               Only instantiated when HAZARD_PERF_EN is defined.
// Ports       : clk, reset_n      - clock, async active-low reset
//               stall_i           - count this cycle as a stall cycle
//               flush_entry_i     - count one flush entry (one per branch)
//               stall_cnt_o       - saturating stall-cycle count
//               flush_cnt_o       - saturating flush-entry count
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_perf_cnt (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall_i,
    input  logic        flush_entry_i,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
);

    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            // Counters stick at all-ones rather than wrapping
            if (stall_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush_entry_i && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Hazard controller for the 5-stage RV32 pipeline. Shadows the
//               register fields of the instructions in EX, MEM and WB and
//               derives EX operand forwarding selects, load-use stall/bubble
//               and taken-branch flush. Owns no datapath.
// Config      : HAZARD_PERF_EN - adds perf_stall_cnt / perf_flush_cnt outputs
// Ports       : clk, reset_n             - clock, async active-low reset
//               id_*                     - decoded fields of the ID instruction
//               ex_branch_taken          - EX resolved a taken branch/jump
//               stall_if_id              - hold PC and IF/ID
//               bubble_ex                - load NOP into ID/EX
//               flush                    - kill IF/ID and ID/EX
//               fwd_a, fwd_b             - EX operand A/B source select
//               perf_*_cnt (optional)    - saturating event counters
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW       = 5,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              ex_branch_taken,
    output logic              stall_if_id,
    output logic              bubble_ex,
    output logic              flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
`ifdef HAZARD_PERF_EN
   ,output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);

    // Counter holds the flush cycles remaining after the entry cycle
    localparam int                CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [REG_AW-1:0] X0    = REG_AW'(REG_X0);

    // Shadow pipeline registers
    logic [REG_AW-1:0] ex_rs1_q, ex_rs2_q, ex_rd_q, mem_rd_q, wb_rd_q;
    logic              ex_rw_q, ex_ld_q, mem_rw_q, wb_rw_q;
    logic [REG_AW-1:0] ex_rs1_d, ex_rs2_d, ex_rd_d;
    logic              ex_rw_d, ex_ld_d;

    hz_state_t         state_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              load_use;
    logic              flush_entry;
    logic              flush_w;
    logic              stall_w;
    logic              ex_bubble;
    fwd_sel_t          fwd_a_sel;
    fwd_sel_t          fwd_b_sel;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    always_comb begin
        load_use = ex_ld_q && ex_rw_q && (ex_rd_q != X0) && id_valid &&
                   ((ex_rd_q == id_rs1) || (id_uses_rs2 && (ex_rd_q == id_rs2)));

        // A taken branch reported while already flushing belongs to a
        // squashed instruction, so only RUN can start a flush. Gating with
        // reset_n keeps flush low for the whole reset window.
        flush_entry = reset_n && (state_q == RUN) && ex_branch_taken;
        flush_w     = flush_entry || (state_q == FLUSH);

        // Flush already kills ID, so it takes precedence over the stall
        stall_w     = load_use && !flush_w;
        ex_bubble   = !id_valid || load_use || flush_w;

        ex_rs1_d = ex_bubble ? '0 : id_rs1;
        ex_rs2_d = ex_bubble ? '0 : id_rs2;
        ex_rd_d  = ex_bubble ? '0 : id_rd;
        ex_rw_d  = ex_bubble ? 1'b0 : id_reg_write;
        ex_ld_d  = ex_bubble ? 1'b0 : id_mem_read;
    end

    // ------------------------------------------------------------------
    // Forwarding selects from shadow state
    // ------------------------------------------------------------------
    always_comb begin
        fwd_a_sel = fwd_select(mem_rw_q && (mem_rd_q != X0) && (mem_rd_q == ex_rs1_q),
                               wb_rw_q  && (wb_rd_q  != X0) && (wb_rd_q  == ex_rs1_q));
        fwd_b_sel = fwd_select(mem_rw_q && (mem_rd_q != X0) && (mem_rd_q == ex_rs2_q),
                               wb_rw_q  && (wb_rd_q  != X0) && (wb_rd_q  == ex_rs2_q));
    end

    // ------------------------------------------------------------------
    // Shadow register advance
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_rs1_q <= '0;
            ex_rs2_q <= '0;
            ex_rd_q  <= '0;
            ex_rw_q  <= 1'b0;
            ex_ld_q  <= 1'b0;
            mem_rd_q <= '0;
            mem_rw_q <= 1'b0;
            wb_rd_q  <= '0;
            wb_rw_q  <= 1'b0;
        end else begin
            ex_rs1_q <= ex_rs1_d;
            ex_rs2_q <= ex_rs2_d;
            ex_rd_q  <= ex_rd_d;
            ex_rw_q  <= ex_rw_d;
            ex_ld_q  <= ex_ld_d;
            mem_rd_q <= ex_rd_q;
            mem_rw_q <= ex_rw_q;
            wb_rd_q  <= mem_rd_q;
            wb_rw_q  <= mem_rw_q;
        end
    end

    // ------------------------------------------------------------------
    // Flush FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    // A single-cycle flush is fully covered by the entry cycle
                    if (ex_branch_taken && (FLUSH_CYCLES > 1)) begin
                        state_q <= FLUSH;
                        cnt_q   <= CNT_W'(FLUSH_CYCLES - 1);
                    end
                end
                FLUSH: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_q - CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign stall_if_id = stall_w;
    assign bubble_ex   = stall_w;
    assign flush       = flush_w;
    assign fwd_a       = fwd_a_sel;
    assign fwd_b       = fwd_b_sel;

`ifdef HAZARD_PERF_EN
    hazard_perf_cnt u_perf_cnt (
        .clk           (clk),
        .reset_n       (reset_n),
        .stall_i       (stall_w),
        .flush_entry_i (flush_entry),
        .stall_cnt_o   (perf_stall_cnt),
        .flush_cnt_o   (perf_flush_cnt)
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl. A behavioural model
//               tracks the instructions occupying EX/MEM/WB as records and
//               derives the expected controls from the hazard rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int AW = 5;
    localparam int FC = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          id_valid = 1'b0;
    logic [AW-1:0] id_rs1 = '0;
    logic [AW-1:0] id_rs2 = '0;
    logic          id_uses_rs2 = 1'b0;
    logic [AW-1:0] id_rd = '0;
    logic          id_reg_write = 1'b0;
    logic          id_mem_read = 1'b0;
    logic          ex_branch_taken = 1'b0;
    logic          stall_if_id;
    logic          bubble_ex;
    logic          flush;
    logic [1:0]    fwd_a;
    logic [1:0]    fwd_b;
`ifdef HAZARD_PERF_EN
    logic [31:0]   perf_stall_cnt;
    logic [31:0]   perf_flush_cnt;
`endif

    always #5 clk = ~clk;

    hazard_ctrl #(
        .REG_AW       (AW),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs2     (id_uses_rs2),
        .id_rd           (id_rd),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .stall_if_id     (stall_if_id),
        .bubble_ex       (bubble_ex),
        .flush           (flush),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b)
`ifdef HAZARD_PERF_EN
       ,.perf_stall_cnt  (perf_stall_cnt),
        .perf_flush_cnt  (perf_flush_cnt)
`endif
    );

    // Reference model: one record per pipeline stage
    typedef struct {
        bit rw;
        bit ld;
        int rd;
        int rs1;
        int rs2;
    } instr_t;

    instr_t m_ex, m_mem, m_wb;
    int     m_flush_left;
    int     m_stalls;
    int     m_branches;

    int     n_checks = 0;
    int     n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Newest producer of src wins; x0 and non-writers never supply data
    function automatic int fwd_of(input int src);
        if (m_mem.rw && m_mem.rd != 0 && m_mem.rd == src) return 1;
        if (m_wb.rw  && m_wb.rd  != 0 && m_wb.rd  == src) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        m_ex  = '{0, 0, 0, 0, 0};
        m_mem = '{0, 0, 0, 0, 0};
        m_wb  = '{0, 0, 0, 0, 0};
        m_flush_left = 0;
        m_stalls     = 0;
        m_branches   = 0;
    endtask

    // Present one ID instruction for one cycle, check controls, advance model
    task automatic cycle(input bit v, input int rs1, input int rs2, input bit u2,
                         input int rd, input bit rw, input bit ld, input bit br);
        bit fl, lu, st;
        @(negedge clk);
        id_valid        = v;
        id_rs1          = rs1[AW-1:0];
        id_rs2          = rs2[AW-1:0];
        id_uses_rs2     = u2;
        id_rd           = rd[AW-1:0];
        id_reg_write    = rw;
        id_mem_read     = ld;
        ex_branch_taken = br;
        #1;
        fl = (m_flush_left > 0) || br;
        lu = m_ex.ld && m_ex.rw && m_ex.rd != 0 && v &&
             (m_ex.rd == rs1 || (u2 && m_ex.rd == rs2));
        st = lu && !fl;
        check("flush",  {31'd0, flush},       {31'd0, fl});
        check("stall",  {31'd0, stall_if_id}, {31'd0, st});
        check("bubble", {31'd0, bubble_ex},   {31'd0, st});
        check("fwd_a",  {30'd0, fwd_a},       fwd_of(m_ex.rs1));
        check("fwd_b",  {30'd0, fwd_b},       fwd_of(m_ex.rs2));
        @(posedge clk);
        if (st) m_stalls++;
        if (m_flush_left > 0) begin
            m_flush_left--;
        end else if (br) begin
            m_flush_left = FC - 1;
            m_branches++;
        end
        m_wb  = m_mem;
        m_mem = m_ex;
        if (v && !lu && !fl) m_ex = '{rw, ld, rd, rs1, rs2};
        else                 m_ex = '{0, 0, 0, 0, 0};
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        #1;
        check("rst_flush", {31'd0, flush},       0);
        check("rst_stall", {31'd0, stall_if_id}, 0);
        check("rst_bub",   {31'd0, bubble_ex},   0);
        check("rst_fwd_a", {30'd0, fwd_a},       0);
        check("rst_fwd_b", {30'd0, fwd_b},       0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // RAW distance 1 on both operands
        cycle(1, 1, 2, 1, 5, 1, 0, 0);
        cycle(1, 5, 5, 1, 6, 1, 0, 0);
        #1;
        check("raw1_a", {30'd0, fwd_a}, 1);
        check("raw1_b", {30'd0, fwd_b}, 1);
        idle(); idle();

        // RAW distance 2 on rs2
        cycle(1, 0, 0, 0, 7, 1, 0, 0);
        cycle(1, 1, 2, 1, 8, 1, 0, 0);
        cycle(1, 3, 7, 1, 9, 1, 0, 0);
        #1;
        check("raw2_b", {30'd0, fwd_b}, 2);
        // Same rd at distance 1 and 2: MEM must win
        cycle(1, 0, 0, 0, 7, 1, 0, 0);
        cycle(1, 0, 0, 0, 7, 1, 0, 0);
        cycle(1, 7, 0, 0, 1, 1, 0, 0);
        #1;
        check("mem_win", {30'd0, fwd_a}, 1);
        idle(); idle();

        // Load-use: one stall cycle, then forward from WB
        cycle(1, 0, 0, 0, 9, 1, 1, 0);
        cycle(1, 9, 0, 0, 10, 1, 0, 0);
        cycle(1, 9, 0, 0, 10, 1, 0, 0);
        #1;
        check("lu_wb", {30'd0, fwd_a}, 2);
        // rs2 match but rs2 unused: no stall
        cycle(1, 0, 0, 0, 9, 1, 1, 0);
        cycle(1, 1, 9, 0, 10, 1, 0, 0);
        idle(); idle();

        // x0 load then reader of x0
        cycle(1, 0, 0, 0, 0, 1, 1, 0);
        cycle(1, 0, 0, 1, 3, 1, 0, 0);
        #1;
        check("x0_fwd", {30'd0, fwd_a}, 0);
        idle(); idle();

        // Branch: second taken pulse during flush is ignored
        cycle(1, 1, 1, 0, 2, 1, 0, 1);
        cycle(1, 1, 1, 0, 2, 1, 0, 1);
        cycle(1, 1, 1, 0, 2, 1, 0, 0);
        // Flush coincident with a load-use
        cycle(1, 0, 0, 0, 4, 1, 1, 0);
        cycle(1, 4, 0, 0, 5, 1, 0, 1);
        idle(); idle(); idle();

        // Randomised traffic over a small register set to provoke hazards
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 9) != 0),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, 3)),
                  $urandom_range(0, 4) != 0,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 9) == 0);
        end
`ifdef HAZARD_PERF_EN
        #1;
        check("perf_stall", perf_stall_cnt, m_stalls);
        check("perf_flush", perf_flush_cnt, m_branches);
`endif

        // Reset asserted in the middle of a flush
        cycle(1, 1, 2, 1, 3, 1, 0, 1);
        @(negedge clk);
        ex_branch_taken = 1'b0;
        id_valid        = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_flush", {31'd0, flush},       0);
        check("mid_stall", {31'd0, stall_if_id}, 0);
        check("mid_fwd_a", {30'd0, fwd_a},       0);
        check("mid_fwd_b", {30'd0, fwd_b},       0);
`ifdef HAZARD_PERF_EN
        check("mid_pstall", perf_stall_cnt, 0);
        check("mid_pflush", perf_flush_cnt, 0);
`endif
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        // Back in RUN: no residual flush, fresh traffic behaves normally
        idle();
        cycle(1, 0, 0, 0, 6, 1, 1, 0);
        cycle(1, 6, 0, 0, 7, 1, 0, 0);
        cycle(1, 6, 0, 0, 7, 1, 0, 0);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
